// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Helpers work on fixed-width vectors; callers cast to their own device count.
package bus_arb_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned MAX_DRV = 32;
    localparam int unsigned IDX_W   = $clog2(MAX_DRV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2,
        PUSH = 2'd3
    } arb_state_e;

    // First requester at or after ptr, searching circularly over n devices.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_DRV-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_DRV; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % n;
            if (!found && (i < n) && req[IDX_W'(idx)]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Target set for a destination field; empty means undeliverable.
    function automatic logic [MAX_DRV-1:0] dst_mask(
        input logic [ADDR_W-1:0] dst,
        input logic [IDX_W-1:0]  src,
        input int unsigned       drvrs,
        input logic [ADDR_W-1:0] broadcast
    );
        logic [MAX_DRV-1:0] m;
        m = '0;
        if (dst == broadcast) begin
            for (int unsigned i = 0; i < MAX_DRV; i++) begin
                m[IDX_W'(i)] = (i < drvrs) && (i != 32'(src));
            end
        end else if (32'(dst) < drvrs) begin
            m[IDX_W'(dst)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_arb_lane.sv
// One bus lane: grant a pending source, pop its head, decode the destination,
// wait for room at every target, then push once (or drop).
module bus_arb_lane
    import bus_arb_pkg::*;
#(
    parameter int unsigned       drvrs     = 4,
    parameter int unsigned       pckg_sz   = 16,
    parameter logic [ADDR_W-1:0] broadcast = 8'h8F,
    parameter int unsigned       max_wait  = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop,
    input  logic [drvrs-1:0]                 full,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [drvrs-1:0][pckg_sz-1:0]    d_push,
    output logic                             busy,
    output logic [15:0]                      drop_cnt
);

    localparam int unsigned SEL_W  = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam int unsigned WAIT_W = $clog2(max_wait + 1);
    localparam int unsigned CNT_W  = 16;

    arb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [pckg_sz-1:0]  pkt_q, pkt_d;
    logic [drvrs-1:0]    mask_q, mask_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [drvrs-1:0]    pop_q, pop_d;
    logic [drvrs-1:0]    push_q, push_d;
    logic                busy_q, busy_d;
    logic [SEL_W-1:0]    ptr_nxt_c;

    assign ptr_nxt_c = (grant_q == SEL_W'(drvrs - 1)) ? '0 : grant_q + SEL_W'(1);

    always_comb begin
        logic drop_evt;
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        pkt_d    = pkt_q;
        mask_d   = mask_q;
        wait_d   = wait_q;
        drop_d   = drop_q;
        pop_d    = '0;
        push_d   = '0;
        drop_evt = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (|pndng) begin
                    grant_d = SEL_W'(rr_pick(MAX_DRV'(pndng), IDX_W'(ptr_q), drvrs));
                    pop_d   = drvrs'(1) << grant_d;
                    state_d = POP;
                end
            end
            POP: begin
                pkt_d  = d_pop[grant_q];
                mask_d = drvrs'(dst_mask(d_pop[grant_q][pckg_sz-1 -: ADDR_W],
                                         IDX_W'(grant_q), drvrs, broadcast));
                wait_d = '0;
                if (mask_d == '0) begin
                    drop_evt = 1'b1;
                    ptr_d    = ptr_nxt_c;
                    state_d  = IDLE;
                end else begin
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // All-or-nothing: every target must be ready in the same cycle.
                if ((mask_q & full) == '0) begin
                    push_d  = mask_q;
                    ptr_d   = ptr_nxt_c;
                    state_d = PUSH;
                end else if (wait_q == WAIT_W'(max_wait - 1)) begin
                    drop_evt = 1'b1;
                    ptr_d    = ptr_nxt_c;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop_evt && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            pkt_q   <= '0;
            mask_q  <= '0;
            wait_q  <= '0;
            drop_q  <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            mask_q  <= mask_d;
            wait_q  <= wait_d;
            drop_q  <= drop_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            busy_q  <= busy_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign d_push   = {drvrs{pkt_q}};
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin packet arbiter: one independent lane per bus.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned       bits      = 1,
    parameter int unsigned       drvrs     = 4,
    parameter int unsigned       pckg_sz   = 16,
    parameter logic [ADDR_W-1:0] broadcast = 8'h8F,
    parameter int unsigned       max_wait  = 64
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    input  logic [bits-1:0][drvrs-1:0]               full,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push,
    output logic [bits-1:0]                          busy,
    output logic [bits-1:0][15:0]                    drop_cnt
);

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bus_arb_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast),
            .max_wait  (max_wait)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng    (pndng[b]),
            .d_pop    (D_pop[b]),
            .full     (full[b]),
            .pop      (pop[b]),
            .push     (push[b]),
            .d_push   (D_push[b]),
            .busy     (busy[b]),
            .drop_cnt (drop_cnt[b])
        );
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: emulated source FIFOs, directed scenarios and
// random traffic checked against a packet-level timing model.
module tb_bus_rr_arbiter;

    localparam int unsigned BITS  = 1;
    localparam int unsigned DRVRS = 5;
    localparam int unsigned PW    = 16;
    localparam int unsigned MAXW  = 8;
    localparam logic [7:0]  BCAST = 8'h8F;

    logic clk = 1'b0;
    logic reset;
    logic [BITS-1:0][DRVRS-1:0]         pndng, full, pop, push;
    logic [BITS-1:0][DRVRS-1:0][PW-1:0] D_pop, D_push;
    logic [BITS-1:0]                    busy;
    logic [BITS-1:0][15:0]              drop_cnt;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .bits(BITS), .drvrs(DRVRS), .pckg_sz(PW), .broadcast(BCAST), .max_wait(MAXW)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
        .pop(pop), .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Source FIFOs and full control owned by the bench.
    logic [PW-1:0]    srcq [DRVRS][$];
    logic [DRVRS-1:0] full_rand, full_force, prev_pop;
    int               force_cnt;
    bit               rand_mode;

    // Packet-level model, indexed by posedge number k since reset release.
    int          k, m_ptr, m_idle_from, m_g, m_src, m_stall, m_drops;
    bit          m_has;
    logic [PW-1:0]    m_pkt, exp_data;
    logic [DRVRS-1:0] m_mask, exp_pop, exp_push;
    bit          exp_busy;

    // Observations for directed checks.
    int          obs_grants[$];
    int          obs_pop_edge, obs_push_edge, n_push_obs;
    logic [DRVRS-1:0] obs_push_val;
    logic [PW-1:0]    obs_push_data;

    task automatic drive();
        for (int d = 0; d < DRVRS; d++) begin
            pndng[0][d] = (srcq[d].size() != 0);
            D_pop[0][d] = (srcq[d].size() != 0) ? srcq[d][0] : '0;
        end
        full[0] = full_rand | ((force_cnt > 0) ? full_force : '0);
    endtask

    task automatic model_reset();
        k = 0; m_ptr = 0; m_idle_from = 1; m_has = 0; m_drops = 0; prev_pop = '0;
    endtask

    task automatic model_drop();
        m_has = 0;
        if (m_drops < 65535) m_drops++;
        m_ptr = (m_src + 1) % DRVRS;
        m_idle_from = k + 1;
    endtask

    // Expected outputs after posedge k, given the inputs seen at that edge.
    task automatic model_edge();
        logic [DRVRS-1:0] in_pend, in_full;
        in_pend = pndng[0];
        in_full = full[0];
        exp_pop = '0;
        exp_push = '0;
        if (m_has) begin
            if (k == m_g + 1) begin
                int dst;
                dst = int'(m_pkt[PW-1 -: 8]);
                if (dst == int'(BCAST)) m_mask = 5'h1F & ~(5'b1 << m_src);
                else if (dst < int'(DRVRS)) m_mask = 5'b1 << dst;
                else m_mask = '0;
                m_stall = 0;
                if (m_mask == '0) model_drop();
            end else if ((m_mask & in_full) == '0) begin
                exp_push = m_mask;
                exp_data = m_pkt;
                m_has = 0;
                m_ptr = (m_src + 1) % DRVRS;
                m_idle_from = k + 2;
            end else begin
                m_stall++;
                if (m_stall == int'(MAXW)) model_drop();
            end
        end else if (k >= m_idle_from && in_pend != '0) begin
            bit found;
            found = 0;
            for (int i = 0; i < DRVRS; i++) begin
                int c;
                c = (m_ptr + i) % DRVRS;
                if (!found && in_pend[c]) begin
                    found = 1;
                    m_src = c;
                end
            end
            exp_pop = 5'b1 << m_src;
            m_has = 1;
            m_g = k;
            m_pkt = srcq[m_src][0];
        end
        exp_busy = m_has || (k + 1 < m_idle_from);
    endtask

    function automatic logic [PW-1:0] rand_pkt(input int src);
        int r;
        logic [7:0] dst;
        r = int'($urandom_range(0, 9));
        if (r <= 5) dst = 8'(r);
        else if (r <= 7) dst = BCAST;
        else if (r == 8) dst = 8'($urandom_range(6, 255));
        else dst = 8'(src);
        return {dst, 8'($urandom)};
    endfunction

    task automatic tick();
        @(negedge clk);
        k++;
        for (int d = 0; d < DRVRS; d++)
            if (prev_pop[d] && srcq[d].size() != 0) void'(srcq[d].pop_front());
        model_edge();
        check("pop", 32'(pop[0]), 32'(exp_pop));
        check("push", 32'(push[0]), 32'(exp_push));
        if (exp_push != '0)
            for (int d = 0; d < DRVRS; d++) check("d_push", 32'(D_push[0][d]), 32'(exp_data));
        check("busy", 32'(busy[0]), 32'(exp_busy));
        check("drop_cnt", 32'(drop_cnt[0]), 32'(m_drops));
        if (pop[0] != '0) begin
            for (int d = 0; d < DRVRS; d++) if (pop[0][d]) obs_grants.push_back(d);
            obs_pop_edge = k;
        end
        if (push[0] != '0) begin
            obs_push_edge = k;
            obs_push_val  = push[0];
            obs_push_data = D_push[0][0];
            n_push_obs++;
        end
        prev_pop = pop[0];
        if (force_cnt > 0) force_cnt--;
        full_rand = '0;
        if (rand_mode) begin
            for (int d = 0; d < DRVRS; d++) begin
                if (srcq[d].size() < 4 && $urandom_range(0, 3) == 0) srcq[d].push_back(rand_pkt(d));
                if ($urandom_range(0, 99) < 25) full_rand[d] = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                full_force = 5'($urandom);
                force_cnt  = 12;
            end
        end
        drive();
    endtask

    task automatic run_idle(input string tag, input int bound);
        bit done;
        done = 0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            done = !m_has && (k + 1 >= m_idle_from);
            for (int d = 0; d < DRVRS; d++) if (srcq[d].size() != 0) done = 0;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic clear_obs();
        obs_grants.delete();
        n_push_obs = 0;
        obs_pop_edge = 0;
        obs_push_edge = 0;
    endtask

    initial begin
        int rr_exp[6] = '{0, 2, 4, 0, 2, 4};
        full_rand = '0; full_force = '0; force_cnt = 0; rand_mode = 0;
        model_reset();
        clear_obs();
        reset = 1'b1;
        drive();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pop", 32'(pop[0]), 32'd0);
        check("rst_push", 32'(push[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_drop", 32'(drop_cnt[0]), 32'd0);
        check("rst_dpush", 32'(D_push[0][0]), 32'd0);
        reset = 1'b1;
        model_reset();

        // Round robin across continuously pending sources 0, 2, 4.
        for (int i = 0; i < 2; i++) begin
            srcq[0].push_back(16'h0300 | 16'(i));
            srcq[2].push_back(16'h0310 | 16'(i));
            srcq[4].push_back(16'h0320 | 16'(i));
        end
        drive();
        run_idle("rr_idle", 60);
        check("rr_count", 32'(obs_grants.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < obs_grants.size()) check("rr_order", 32'(obs_grants[i]), 32'(rr_exp[i]));

        // Unicast dev1 -> dev3.
        clear_obs();
        srcq[1].push_back(16'h03AB);
        drive();
        run_idle("uni_idle", 20);
        check("uni_lat", 32'(obs_push_edge - obs_pop_edge), 32'd2);
        check("uni_mask", 32'(obs_push_val), 32'h08);
        check("uni_data", 32'(obs_push_data), 32'h03AB);

        // Broadcast from dev2, then again with dev4 full for 3 WAIT cycles.
        clear_obs();
        srcq[2].push_back(16'h8F55);
        drive();
        run_idle("bc_idle", 20);
        check("bc_mask", 32'(obs_push_val), 32'h1B);
        check("bc_data", 32'(obs_push_data), 32'h8F55);
        check("bc_lat", 32'(obs_push_edge - obs_pop_edge), 32'd2);
        clear_obs();
        srcq[2].push_back(16'h8F55);
        full_force = 5'b10000;
        force_cnt = 5;
        drive();
        run_idle("bcf_idle", 20);
        check("bcf_lat", 32'(obs_push_edge - obs_pop_edge), 32'd5);
        check("bcf_pushes", 32'(n_push_obs), 32'd1);
        check("bcf_mask", 32'(obs_push_val), 32'h1B);

        // Bad address, then timeout on a stuck-full target.
        clear_obs();
        srcq[0].push_back(16'h0711);
        drive();
        run_idle("bad_idle", 20);
        check("bad_drop", 32'(drop_cnt[0]), 32'd1);
        check("bad_nopush", 32'(n_push_obs), 32'd0);
        srcq[3].push_back(16'h0122);
        full_force = 5'b00010;
        force_cnt = 20;
        drive();
        run_idle("to_idle", 40);
        check("to_drop", 32'(drop_cnt[0]), 32'd2);
        check("to_nopush", 32'(n_push_obs), 32'd0);
        check("to_busy", 32'(busy[0]), 32'd0);
        force_cnt = 0;
        drive();

        // Reset while a packet waits on a full target.
        srcq[2].push_back(16'h0466);
        full_force = 5'b10000;
        force_cnt = 30;
        drive();
        for (int i = 0; i < 20 && !(m_has && k >= m_g + 3); i++) tick();
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pop", 32'(pop[0]), 32'd0);
        check("mid_rst_push", 32'(push[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt[0]), 32'd0);
        check("mid_rst_dpush", 32'(D_push[0][3]), 32'd0);
        force_cnt = 0;
        srcq[3].push_back(16'h0077);
        srcq[1].push_back(16'h0288);
        drive();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        clear_obs();
        tick();
        check("rst_grant", 32'(pop[0]), 32'h02);
        run_idle("rst_idle", 30);

        // Random traffic with random and bursty back-pressure.
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        force_cnt = 0;
        drive();
        run_idle("drain_idle", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin controller that shares each bus among `drvrs` devices. Per bus it grants one pending device, pops its head packet, decodes the 8-bit destination field, and pushes the packet to the addressed device, or to every other device on broadcast. It sits between the per-device FIFO/driver layer and the bus fabric. It exposes the same pndng/pop/push/D_pop/D_push signal set as the bus generator/arbiter so the existing bus interface and bench drivers attach unchanged.

## Interface
- `bits`, 1: number of independent buses, each arbitrated separately.
- `drvrs`, 4: devices per bus.
- `pckg_sz`, 16: packet width. The destination is `pckg[pckg_sz-1 -: 8]`. Legal values are >= 9.
- `broadcast`, 8'h8F: destination value meaning "all devices except source".
- `max_wait`, 64: cycles a granted packet may stall on full targets before it is dropped. Legal values are >= 1.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `pndng`, in, [bits][drvrs]: source FIFO non-empty.
- `D_pop`, in, [bits][drvrs][pckg_sz]: source FIFO head, first-word-fall-through.
- `full`, in, [bits][drvrs]: target FIFO cannot accept a push.
- `pop`, out, [bits][drvrs]: one-cycle pop strobe to the granted source.
- `push`, out, [bits][drvrs]: one-cycle push strobe to the target(s).
- `D_push`, out, [bits][drvrs][pckg_sz]: packet, replicated to every device of the bus.
- `busy`, out, [bits]: lane is not in IDLE.
- `drop_cnt`, out, [bits][16]: saturating count of dropped packets per bus.

## Operation
Each bus runs its own FSM with states IDLE, POP, WAIT, PUSH.

- **IDLE:**
  - If any `pndng` bit is set, grant the first pending index at or after `ptr`, searching circularly. Go to POP.
  - Otherwise stay in IDLE.
- **POP:**
  - Assert `pop[grant]` for exactly one cycle.
  - Register `D_pop[grant]` into `pkt`, and `grant` into `src`.
  - Decode `dst = pkt[pckg_sz-1 -: 8]`:
    - `dst == broadcast`: target mask is all devices except `src`.
    - `dst < drvrs`: target mask is one-hot `dst`. `dst == src` is legal and is delivered.
    - Any other value: mask is empty. Drop the packet, go to IDLE.
  - Otherwise go to WAIT.
- **WAIT:**
  - When `(mask & full) == 0`, go to PUSH.
  - A wait counter increments every stalled cycle. When it reaches `max_wait`, drop the packet and go to IDLE.
- **PUSH:**
  - Assert `push = mask` for one cycle, with `D_push = pkt` on all devices.
  - Go to IDLE.
- **Pointer:** `ptr <= src + 1` (wrapping at `drvrs`) whenever a packet leaves WAIT or POP, whether delivered or dropped. Fairness is therefore per packet, not per cycle.
- **Drop:** `drop_cnt` increments once per dropped packet and saturates at 16'hFFFF.
- **Broadcast delivery:** all-or-nothing. A broadcast pushes only when every target in the mask is non-full.

## Timing
- **Reset (async assert, any state):** `pop`, `push`, `D_push`, and `drop_cnt` go to 0, `busy` to 0, `ptr` to 0, state to IDLE, wait counter to 0. A packet already popped but not yet pushed is lost and is not counted.
- **Minimum latency:** `pndng` seen in IDLE at edge N gives `pop` high during cycle N+1 and `push` high during cycle N+3.
- **Throughput:** at most one packet per bus every 4 cycles.
- `pndng[grant]` is not sampled again until the lane returns to IDLE. A source deasserting `pndng` in the same cycle as `pop` is legal.
- `D_push` holds `pkt` from WAIT until the next POP. Receivers must qualify it with `push` only.
- **Simultaneous requests:** with `ptr = k`, device k wins if pending, else the next pending index, wrapping past `drvrs-1` to 0.
- **Full toggling in WAIT:** the decision is taken each cycle on the current `full`. There is no hysteresis.

## Structure
- **Package `bus_arb_pkg`:**
  - `arb_state_e` enum (IDLE, POP, WAIT, PUSH).
  - `localparam ADDR_W = 8`.
  - `function rr_pick(req, ptr)` returning the grant index.
  - `function dst_mask(dst, src, drvrs, broadcast)`.
- **Sub-module `bus_arb_lane`:** one bus FSM, instantiated `bits` times by a generate loop in `bus_rr_arbiter`. The top module contains only that loop and the port slicing.

## Test plan
All scenarios use drvrs=5, pckg_sz=16, broadcast=8'h8F, max_wait=8, bits=1.

1. **Unicast:** dev1 head = 16'h03AB, all `full` = 0. Expect `pop[1]` one cycle, then 2 cycles later `push` = 5'b01000 with `D_push` = 16'h03AB.
2. **Round robin:** devs 0, 2, 4 all continuously pending. Expect grants in order 0, 2, 4, 0, … with `ptr` wrap verified.
3. **Broadcast:** dev2 sends 16'h8F55. Expect one `push` = 5'b11011 with 16'h8F55. Repeat with `full[4]` held 3 cycles: the push occurs 3 cycles later, still as a single strobe.
4. **Bad address and timeout:**
   - dev0 sends 16'h0711. Expect no push, `drop_cnt` = 1.
   - dev3 to dev1 with `full[1]` stuck high. After 8 WAIT cycles the packet is dropped, `drop_cnt` = 2, and the lane returns to IDLE.
5. **Reset mid-operation:** assert `reset` low during WAIT. Outputs go to 0 immediately, `busy` = 0. After release, `ptr` = 0 and the next grant goes to the lowest pending index.
